memory_access: RTL and testbench

Fourth pipeline stage (MEM): takes the EX/MEM latch contents, performs loads and stores over the data-bus request/response port, and drives the registered MEM/WB latch that feeds the writeback stage. Non-memory instructions pass through in one cycle. Memory instructions stall the upstream pipeline until the bus completes. Load data is byte-aligned and sign- or zero-extended here, so writeback only selects between memory and ALU data.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/memory_access_if.sv | 23 ++
 rtl/load_align.sv | 28 ++
 rtl/memory_access.sv | 147 ++++++++++++++
 tb/tb_memory_access.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage: FSM states, funct3 encodings,
// and the byte-lane size/alignment helpers used by both the stage and the bench.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // funct3[1:0] encodes the access size for every legal load and store
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-bus request/response port of the MEM stage; master is the stage, slave is memory.
interface memory_access_if;

  logic        dreq_valid;
  logic        dreq_ready;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [63:0] dreq_wdata;
  logic [7:0]  dreq_wstrb;
  logic        dresp_valid;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_write, dreq_wdata, dreq_wstrb,
    input  dreq_ready, dresp_valid, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_write, dreq_wdata, dreq_wstrb,
    output dreq_ready, dresp_valid, dresp_data
  );

endinterface

// File: rtl/load_align.sv
// Combinational load aligner: shifts the byte at offset down to lane 0, then sign/zero-extends.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] dresp_data,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  assign shifted = dresp_data >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  result = {56'd0, shifted[7:0]};
      F3_LHU:  result = {48'd0, shifted[15:0]};
      F3_LWU:  result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: non-memory and faulting ops reach the MEM/WB latch one edge after acceptance;
// loads/stores hold out_stall high through REQ/WAIT and land on the bus response edge.
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [BUS_DATA_WIDTH-1:0] in_alu_data,
  input  logic [BUS_DATA_WIDTH-1:0] in_store_data,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic [2:0]                in_funct3,
  input  logic [4:0]                in_dest_reg,
  input  logic                      in_reg_write,
  input  logic                      in_mem_or_reg,
  output logic                      out_stall,
  memory_access_if.master           bus,
  output logic                      out_valid,
  output logic [BUS_DATA_WIDTH-1:0] out_read_data,
  output logic [BUS_DATA_WIDTH-1:0] out_alu_data,
  output logic [4:0]                out_dest_reg,
  output logic                      out_reg_write,
  output logic                      out_mem_or_reg,
  output logic                      out_fault
);

  state_t state, state_nxt;

  logic [2:0]                h_off;
  logic [2:0]                h_f3;
  logic                      h_write;
  logic [4:0]                h_dest;
  logic                      h_reg_write;
  logic                      h_mem_or_reg;
  logic [BUS_DATA_WIDTH-1:0] h_alu;
  logic [63:0]               load_data;

  logic       accept, is_mem, f3_ok, bad, mem_go, resp_hit;
  logic [2:0] in_off;

  assign in_off   = in_alu_data[2:0];
  assign accept   = (state == IDLE) && in_valid;
  assign is_mem   = in_mem_read | in_mem_write;
  assign f3_ok    = in_mem_write ? (in_funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD})
                                 : (in_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LD,
                                                      F3_LBU, F3_LHU, F3_LWU});
  assign bad      = is_mem && (!f3_ok || misaligned(in_funct3[1:0], in_off));
  assign mem_go   = accept && is_mem && !bad;
  // Responses outside WAIT belong to nothing we issued (e.g. abandoned by reset)
  assign resp_hit = (state == WAIT) && bus.dresp_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    out_stall      = 1'b0;
    bus.dreq_valid = 1'b0;
    case (state)
      IDLE: if (mem_go) state_nxt = REQ;
      REQ: begin
        out_stall      = 1'b1;
        bus.dreq_valid = 1'b1;
        if (bus.dreq_ready) state_nxt = WAIT;
      end
      WAIT: begin
        out_stall = 1'b1;
        if (bus.dresp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request and holding registers only change on capture, so dreq_* is stable in REQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.dreq_addr  <= '0;
      bus.dreq_write <= 1'b0;
      bus.dreq_wdata <= '0;
      bus.dreq_wstrb <= '0;
      h_off          <= '0;
      h_f3           <= '0;
      h_write        <= 1'b0;
      h_dest         <= '0;
      h_reg_write    <= 1'b0;
      h_mem_or_reg   <= 1'b0;
      h_alu          <= '0;
    end else if (mem_go) begin
      bus.dreq_addr  <= {in_alu_data[63:3], 3'b000};
      bus.dreq_write <= in_mem_write;
      bus.dreq_wdata <= in_mem_write ? (in_store_data << {in_off, 3'b000}) : '0;
      bus.dreq_wstrb <= in_mem_write ? (size_mask(in_funct3[1:0]) << in_off) : 8'h00;
      h_off          <= in_off;
      h_f3           <= in_funct3;
      h_write        <= in_mem_write;
      h_dest         <= in_dest_reg;
      h_reg_write    <= in_reg_write;
      h_mem_or_reg   <= in_mem_or_reg;
      h_alu          <= in_alu_data;
    end
  end

  load_align u_load_align (
    .dresp_data (bus.dresp_data),
    .offset     (h_off),
    .funct3     (h_f3),
    .result     (load_data)
  );

  // MEM/WB latch: bubble by default; out_read_data only moves on a bus response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_read_data  <= '0;
      out_alu_data   <= '0;
      out_dest_reg   <= '0;
      out_reg_write  <= 1'b0;
      out_mem_or_reg <= 1'b0;
      out_fault      <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_fault     <= 1'b0;
      if (accept && (!is_mem || bad)) begin
        out_valid      <= 1'b1;
        out_fault      <= bad;
        out_reg_write  <= in_reg_write && !bad;
        out_alu_data   <= in_alu_data;
        out_dest_reg   <= in_dest_reg;
        out_mem_or_reg <= in_mem_or_reg;
      end else if (resp_hit) begin
        out_valid      <= 1'b1;
        out_reg_write  <= h_reg_write;
        out_read_data  <= h_write ? '0 : load_data;
        out_alu_data   <= h_alu;
        out_dest_reg   <= h_dest;
        out_mem_or_reg <= h_mem_or_reg;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for the MEM stage: scenario tasks drive the EX/MEM inputs and the bus by hand;
// every expected MEM/WB result is queued at issue time and popped when out_valid appears.
module tb_memory_access;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [63:0] in_alu_data, in_store_data;
  logic        in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [4:0]  in_dest_reg;
  logic        in_reg_write, in_mem_or_reg;
  logic        out_stall, out_valid, out_reg_write, out_mem_or_reg, out_fault;
  logic [63:0] out_read_data, out_alu_data;
  logic [4:0]  out_dest_reg;

  memory_access_if bus ();

  memory_access #(.BUS_DATA_WIDTH(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_alu_data    (in_alu_data),
    .in_store_data  (in_store_data),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_funct3      (in_funct3),
    .in_dest_reg    (in_dest_reg),
    .in_reg_write   (in_reg_write),
    .in_mem_or_reg  (in_mem_or_reg),
    .out_stall      (out_stall),
    .bus            (bus),
    .out_valid      (out_valid),
    .out_read_data  (out_read_data),
    .out_alu_data   (out_alu_data),
    .out_dest_reg   (out_dest_reg),
    .out_reg_write  (out_reg_write),
    .out_mem_or_reg (out_mem_or_reg),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fault;
    logic        reg_write;
    logic        mor;
    logic [4:0]  dest;
    logic [63:0] alu;
    logic [63:0] rdata;
  } res_t;

  res_t        sbq[$];
  logic [63:0] rd_hold;
  int          total = 0;
  int          bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [63:0] addr, input logic [63:0] sdata, input logic rd,
                           input logic wr, input logic [2:0] f3, input logic [4:0] dest,
                           input logic rw, input logic mor);
    in_valid      = 1'b1;
    in_alu_data   = addr;
    in_store_data = sdata;
    in_mem_read   = rd;
    in_mem_write  = wr;
    in_funct3     = f3;
    in_dest_reg   = dest;
    in_reg_write  = rw;
    in_mem_or_reg = mor;
  endtask

  task automatic clear_instr();
    in_valid      = 1'b0;
    in_alu_data   = '0;
    in_store_data = '0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_funct3     = '0;
    in_dest_reg   = '0;
    in_reg_write  = 1'b0;
    in_mem_or_reg = 1'b0;
  endtask

  task automatic push_exp(input logic fault, input logic rw, input logic mor,
                          input logic [4:0] dest, input logic [63:0] alu, input logic [63:0] rdata);
    res_t e;
    e = {fault, rw, mor, dest, alu, rdata};
    sbq.push_back(e);
  endtask

  // Accept, handshake with ready=1, respond on the following edge
  task automatic run_mem(input logic [63:0] addr, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [4:0] dest, input logic [63:0] resp);
    set_instr(addr, 64'h0, rd, wr, f3, dest, 1'b1, 1'b0);
    bus.dreq_ready = 1'b1;
    step();
    clear_instr();
    step();
    bus.dreq_ready  = 1'b0;
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = resp;
    step();
    bus.dresp_valid = 1'b0;
  endtask

  // Scoreboard consumer, sampled on the falling edge
  always @(negedge clk) begin
    res_t act, e;
    if (reset_n && out_valid) begin
      act = {out_fault, out_reg_write, out_mem_or_reg, out_dest_reg, out_alu_data, out_read_data};
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got out_valid=1 alu=%h rdata=%h, required no output",
                 out_alu_data, out_read_data);
      end else begin
        e = sbq.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL sb_result: got f=%b rw=%b mor=%b rd=%0d alu=%h data=%h, required f=%b rw=%b mor=%b rd=%0d alu=%h data=%h",
                   act.fault, act.reg_write, act.mor, act.dest, act.alu, act.rdata,
                   e.fault, e.reg_write, e.mor, e.dest, e.alu, e.rdata);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    clear_instr();
    bus.dreq_ready  = 1'b0;
    bus.dresp_valid = 1'b0;
    bus.dresp_data  = '0;
    rd_hold         = '0;
    repeat (2) step();
    total++;
    if ({out_valid, out_read_data, out_alu_data, out_dest_reg, out_reg_write, out_mem_or_reg,
         out_fault, out_stall, bus.dreq_valid, bus.dreq_addr, bus.dreq_write, bus.dreq_wdata,
         bus.dreq_wstrb} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b stall=%b dreq_valid=%b alu=%h, required all zero",
               out_valid, out_stall, bus.dreq_valid, out_alu_data);
    end
    reset_n = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || out_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got valid=%b stall=%b, required 0 0", out_valid, out_stall);
    end
  endtask

  task automatic test_alu();
    set_instr(64'h1234, 64'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 1'b1);
    push_exp(1'b0, 1'b1, 1'b1, 5'd5, 64'h1234, rd_hold);
    step();
    clear_instr();
    total++;
    if (out_valid !== 1'b1 || out_alu_data !== 64'h1234 || out_dest_reg !== 5'd5) begin
      bad++;
      $display("FAIL alu_latency: got valid=%b alu=%h rd=%0d, required 1 1234 5",
               out_valid, out_alu_data, out_dest_reg);
    end
    total++;
    if (out_stall !== 1'b0) begin
      bad++;
      $display("FAIL alu_stall: got %b, required 0", out_stall);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_fault !== 1'b0) begin
      bad++;
      $display("FAIL alu_bubble: got valid=%b rw=%b fault=%b, required 0 0 0",
               out_valid, out_reg_write, out_fault);
    end
  endtask

  task automatic test_load_byte();
    for (int k = 0; k < 2; k++) begin
      logic [2:0]  f3;
      logic [63:0] expv;
      f3   = (k == 0) ? F3_LB : F3_LBU;
      expv = (k == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80;
      set_instr(64'h1003, 64'h0, 1'b1, 1'b0, f3, 5'd7, 1'b1, 1'b0);
      bus.dreq_ready = 1'b1;
      push_exp(1'b0, 1'b1, 1'b0, 5'd7, 64'h1003, expv);
      rd_hold = expv;
      step();
      clear_instr();
      total++;
      if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h1000 || bus.dreq_write !== 1'b0 ||
          out_stall !== 1'b1) begin
        bad++;
        $display("FAIL lb_req[%0d]: got dreq_valid=%b addr=%h write=%b stall=%b, required 1 1000 0 1",
                 k, bus.dreq_valid, bus.dreq_addr, bus.dreq_write, out_stall);
      end
      step();
      bus.dreq_ready = 1'b0;
      total++;
      if (bus.dreq_valid !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL lb_wait[%0d]: got dreq_valid=%b out_valid=%b, required 0 0",
                 k, bus.dreq_valid, out_valid);
      end
      bus.dresp_valid = 1'b1;
      bus.dresp_data  = 64'h0000_0000_8000_0000;
      step();
      bus.dresp_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_stall !== 1'b0) begin
        bad++;
        $display("FAIL lb_latency[%0d]: got valid=%b stall=%b at edge 3, required 1 0",
                 k, out_valid, out_stall);
      end
    end
  endtask

  task automatic test_store_half();
    set_instr(64'h2006, 64'hBEEF, 1'b0, 1'b1, F3_SH, 5'd0, 1'b0, 1'b0);
    bus.dreq_ready = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 5'd0, 64'h2006, 64'h0);
    rd_hold = 64'h0;
    step();
    clear_instr();
    total++;
    if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h2000 || bus.dreq_wstrb !== 8'hC0 ||
        bus.dreq_wdata !== 64'hBEEF_0000_0000_0000 || bus.dreq_write !== 1'b1) begin
      bad++;
      $display("FAIL sh_lanes: got v=%b addr=%h strb=%h wdata=%h w=%b, required 1 2000 c0 beef000000000000 1",
               bus.dreq_valid, bus.dreq_addr, bus.dreq_wstrb, bus.dreq_wdata, bus.dreq_write);
    end
    step();
    bus.dreq_ready = 1'b1;
    step();
    bus.dreq_ready  = 1'b0;
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    bus.dresp_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_read_data !== 64'h0) begin
      bad++;
      $display("FAIL sh_done: got valid=%b rdata=%h, required 1 0", out_valid, out_read_data);
    end
  endtask

  task automatic test_faults();
    logic [63:0] addrs [6] = '{64'h3002, 64'h3001, 64'h3004, 64'h3000, 64'h3000, 64'h3006};
    logic [2:0]  f3s   [6] = '{3'b010, 3'b001, 3'b011, 3'b111, 3'b100, 3'b010};
    logic        wrs   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      set_instr(addrs[i], 64'h55, !wrs[i], wrs[i], f3s[i], 5'd9, 1'b1, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 5'd9, addrs[i], rd_hold);
      step();
      clear_instr();
      total++;
      if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_reg_write !== 1'b0 ||
          bus.dreq_valid !== 1'b0 || out_stall !== 1'b0) begin
        bad++;
        $display("FAIL fault[%0d]: got valid=%b fault=%b rw=%b dreq_valid=%b stall=%b, required 1 1 0 0 0",
                 i, out_valid, out_fault, out_reg_write, bus.dreq_valid, out_stall);
      end
    end
    step();
    total++;
    if (out_fault !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL fault_pulse: got fault=%b valid=%b, required 0 0", out_fault, out_valid);
    end
  endtask

  task automatic test_ld_stall();
    set_instr(64'h4008, 64'h0, 1'b1, 1'b0, F3_LD, 5'd3, 1'b1, 1'b0);
    bus.dreq_ready = 1'b0;
    push_exp(1'b0, 1'b1, 1'b0, 5'd3, 64'h4008, 64'h0123_4567_89AB_CDEF);
    rd_hold = 64'h0123_4567_89AB_CDEF;
    step();
    clear_instr();
    for (int c = 0; c < 4; c++) begin
      // Stray responses while in REQ must be ignored
      bus.dresp_valid = 1'b1;
      bus.dresp_data  = 64'hFFFF_0000_FFFF_0000;
      total++;
      if (out_stall !== 1'b1 || bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h4008 ||
          bus.dreq_write !== 1'b0) begin
        bad++;
        $display("FAIL ld_stall[%0d]: got stall=%b v=%b addr=%h w=%b, required 1 1 4008 0",
                 c, out_stall, bus.dreq_valid, bus.dreq_addr, bus.dreq_write);
      end
      step();
    end
    bus.dresp_valid = 1'b0;
    bus.dreq_ready  = 1'b1;
    step();
    bus.dreq_ready  = 1'b0;
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = 64'h0123_4567_89AB_CDEF;
    step();
    bus.dresp_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_stall !== 1'b0) begin
      bad++;
      $display("FAIL ld_done: got valid=%b stall=%b, required 1 0", out_valid, out_stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [3] = '{64'h5002, 64'h5002, 64'h5004};
    logic [2:0]  f3s   [3] = '{F3_LH, F3_LHU, F3_LWU};
    logic [63:0] resps [3] = '{64'hABCD_0000, 64'hABCD_0000, 64'h8000_0000_0000_0000};
    logic [63:0] exps  [3] = '{64'hFFFF_FFFF_FFFF_ABCD, 64'hABCD, 64'h8000_0000};
    push_exp(1'b0, 1'b1, 1'b0, 5'd6, 64'h5004, 64'hFFFF_FFFF_8000_0000);
    rd_hold = 64'hFFFF_FFFF_8000_0000;
    run_mem(64'h5004, 1'b1, 1'b0, F3_LW, 5'd6, 64'h8000_0000_0000_0000);
    total++;
    if (out_valid !== 1'b1 || out_stall !== 1'b0) begin
      bad++;
      $display("FAIL b2b_lw: got valid=%b stall=%b, required 1 0", out_valid, out_stall);
    end
    set_instr(64'h77, 64'h0, 1'b0, 1'b0, 3'b000, 5'd4, 1'b1, 1'b1);
    push_exp(1'b0, 1'b1, 1'b1, 5'd4, 64'h77, rd_hold);
    step();
    clear_instr();
    total++;
    if (out_valid !== 1'b1 || out_alu_data !== 64'h77 || out_read_data !== rd_hold) begin
      bad++;
      $display("FAIL b2b_alu: got valid=%b alu=%h rdata=%h, required 1 77 %h",
               out_valid, out_alu_data, out_read_data, rd_hold);
    end
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 1'b1, 1'b0, 5'd10 + 5'(i), addrs[i], exps[i]);
      rd_hold = exps[i];
      run_mem(addrs[i], 1'b1, 1'b0, f3s[i], 5'd10 + 5'(i), resps[i]);
    end
    step();
  endtask

  task automatic test_reset_wait();
    set_instr(64'h6000, 64'h0, 1'b1, 1'b0, F3_LD, 5'd2, 1'b1, 1'b0);
    bus.dreq_ready = 1'b1;
    step();
    clear_instr();
    step();
    bus.dreq_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_read_data, out_alu_data, out_dest_reg, out_reg_write, out_mem_or_reg,
         out_fault, out_stall, bus.dreq_valid, bus.dreq_addr, bus.dreq_write, bus.dreq_wdata,
         bus.dreq_wstrb} !== '0) begin
      bad++;
      $display("FAIL rst_wait: got stall=%b rdata=%h dreq_addr=%h, required all zero",
               out_stall, out_read_data, bus.dreq_addr);
    end
    step();
    reset_n         = 1'b1;
    rd_hold         = '0;
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.dresp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (out_valid !== 1'b0 || out_stall !== 1'b0 || bus.dreq_valid !== 1'b0 ||
          out_read_data !== 64'h0) begin
        bad++;
        $display("FAIL rst_stale_resp[%0d]: got valid=%b stall=%b dreq_valid=%b rdata=%h, required 0 0 0 0",
                 c, out_valid, out_stall, bus.dreq_valid, out_read_data);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_faults();
    test_ld_stall();
    test_back_to_back();
    test_reset_wait();
    step();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d results outstanding, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
